result_writer_bram: RTL and testbench

//   Downstream stage of the 4-core MAC data mover. Accepts result sets (4 x DWIDTH core results

---
 rtl/result_writer_bram.sv | 154 +++++++++++++++
 tb/tb_result_writer_bram.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/result_writer_bram.sv
// Result-set writer: buffers 4-lane result sets in a small FIFO and serialises each set
// into BRAM2 as four consecutive words under IDLE/RUN/DONE register control.
module result_writer_bram #(
  parameter int CNT_BIT    = 31,
  parameter int DWIDTH     = 32,
  parameter int AWIDTH     = 12,
  parameter int MEM_SIZE   = 4096,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start_run_i,
  input  logic [CNT_BIT-1:0] run_count_i,
  input  logic [AWIDTH-1:0]  base_addr_i,
  input  logic               result_valid_i,
  input  logic [DWIDTH-1:0]  result_0_i,
  input  logic [DWIDTH-1:0]  result_1_i,
  input  logic [DWIDTH-1:0]  result_2_i,
  input  logic [DWIDTH-1:0]  result_3_i,
  output logic               ready_o,
  output logic               idle_o,
  output logic               run_o,
  output logic               done_o,
  output logic               overflow_o,
  output logic [AWIDTH-1:0]  addr_b2_o,
  output logic               ce_b2_o,
  output logic               we_b2_o,
  output logic [DWIDTH-1:0]  d_b2_o
);
  localparam int PW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_BIT-1:0] num_cnt_q, num_cnt_d;
  logic [CNT_BIT-1:0] accepted_cnt_q, accepted_cnt_d;
  logic [CNT_BIT-1:0] written_cnt_q, written_cnt_d;
  logic [AWIDTH-1:0]  base_q, base_d;
  logic [AWIDTH-1:0]  addr_q, addr_d;
  logic [1:0]         lane_q, lane_d;
  logic [PW:0]        wr_ptr_q, wr_ptr_d;
  logic [PW:0]        rd_ptr_q, rd_ptr_d;
  logic               overflow_q, overflow_d;
  logic               we_q, we_d;
  logic [DWIDTH-1:0]  d_q, d_d;

  logic [3:0][DWIDTH-1:0] fifo_mem_q [FIFO_DEPTH];
  logic [3:0][DWIDTH-1:0] head_set;
  logic                   fifo_empty, fifo_full, push;
  logic [AWIDTH-1:0]      addr_sum;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign head_set   = fifo_mem_q[rd_ptr_q[PW-1:0]];

  assign ready_o    = (state_q == S_RUN) && !fifo_full && (accepted_cnt_q < num_cnt_q);
  assign push       = result_valid_i && ready_o;

  // Lane index forms the low two address bits of the set's 4-word slot.
  assign addr_sum   = base_q + AWIDTH'({written_cnt_q, lane_q});

  always_comb begin
    state_d        = state_q;
    num_cnt_d      = num_cnt_q;
    accepted_cnt_d = accepted_cnt_q;
    written_cnt_d  = written_cnt_q;
    base_d         = base_q;
    addr_d         = addr_q;
    lane_d         = lane_q;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    overflow_d     = overflow_q;
    we_d           = 1'b0;
    d_d            = d_q;

    if (state_q == S_RUN && !fifo_empty) begin
      we_d   = 1'b1;
      addr_d = addr_sum & AWIDTH'(MEM_SIZE - 1);
      d_d    = head_set[lane_q];
      lane_d = lane_q + 2'd1;
      if (lane_q == 2'd3) begin
        rd_ptr_d      = rd_ptr_q + 1'b1;
        written_cnt_d = written_cnt_q + 1'b1;
      end
    end

    if (push) begin
      wr_ptr_d       = wr_ptr_q + 1'b1;
      accepted_cnt_d = accepted_cnt_q + 1'b1;
    end

    if (state_q == S_RUN && result_valid_i && !ready_o) overflow_d = 1'b1;

    case (state_q)
      S_IDLE: if (start_run_i) begin
        state_d        = S_RUN;
        num_cnt_d      = run_count_i;
        base_d         = base_addr_i;
        overflow_d     = 1'b0;
        accepted_cnt_d = '0;
        written_cnt_d  = '0;
        lane_d         = '0;
        rd_ptr_d       = wr_ptr_q;
      end
      // Compare uses the pre-increment count, so DONE follows the lane-3 write cycle.
      S_RUN:   if (written_cnt_q == num_cnt_q) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      num_cnt_q      <= '0;
      accepted_cnt_q <= '0;
      written_cnt_q  <= '0;
      base_q         <= '0;
      addr_q         <= '0;
      lane_q         <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      overflow_q     <= 1'b0;
      we_q           <= 1'b0;
      d_q            <= '0;
    end else begin
      state_q        <= state_d;
      num_cnt_q      <= num_cnt_d;
      accepted_cnt_q <= accepted_cnt_d;
      written_cnt_q  <= written_cnt_d;
      base_q         <= base_d;
      addr_q         <= addr_d;
      lane_q         <= lane_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      overflow_q     <= overflow_d;
      we_q           <= we_d;
      d_q            <= d_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem_q[wr_ptr_q[PW-1:0]] <= {result_3_i, result_2_i, result_1_i, result_0_i};
  end

  assign idle_o     = (state_q == S_IDLE);
  assign run_o      = (state_q == S_RUN);
  assign done_o     = (state_q == S_DONE);
  assign overflow_o = overflow_q;
  assign addr_b2_o  = addr_q;
  assign we_b2_o    = we_q;
  assign ce_b2_o    = we_q;
  assign d_b2_o     = d_q;
endmodule

// File: tb/tb_result_writer_bram.sv
// Randomized bench for result_writer_bram against a queue-based behavioural model
// of the set FIFO, drain order, address wrap and control flags.
module tb_result_writer_bram;
  logic        clk = 1'b0;
  logic        reset;
  logic        start_run_i;
  logic [30:0] run_count_i;
  logic [11:0] base_addr_i;
  logic        result_valid_i;
  logic [31:0] result_0_i, result_1_i, result_2_i, result_3_i;
  logic        ready_o, idle_o, run_o, done_o, overflow_o;
  logic [11:0] addr_b2_o;
  logic        ce_b2_o, we_b2_o;
  logic [31:0] d_b2_o;

  result_writer_bram dut (
    .clk(clk), .reset(reset), .start_run_i(start_run_i), .run_count_i(run_count_i),
    .base_addr_i(base_addr_i), .result_valid_i(result_valid_i),
    .result_0_i(result_0_i), .result_1_i(result_1_i), .result_2_i(result_2_i),
    .result_3_i(result_3_i), .ready_o(ready_o), .idle_o(idle_o), .run_o(run_o),
    .done_o(done_o), .overflow_o(overflow_o), .addr_b2_o(addr_b2_o), .ce_b2_o(ce_b2_o),
    .we_b2_o(we_b2_o), .d_b2_o(d_b2_o)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Model: 0=idle 1=run 2=done; pending sets kept in a queue in arrival order.
  int           m_st;
  longint       m_num, m_acc, m_wr;
  int           m_lane;
  logic [11:0]  m_base, m_addr;
  logic [31:0]  m_d;
  bit           m_we, m_ovf;
  logic [127:0] m_q[$];
  int unsigned  dseq;

  function automatic bit m_ready();
    return (m_st == 1) && (m_q.size() < 4) && (m_acc < m_num);
  endfunction

  task automatic m_reset();
    m_st = 0; m_num = 0; m_acc = 0; m_wr = 0; m_lane = 0;
    m_base = 0; m_addr = 0; m_d = 0; m_we = 0; m_ovf = 0;
    m_q.delete();
  endtask

  task automatic step(input bit rst, input bit st, input int unsigned cnt,
                      input logic [11:0] b, input bit v, input logic [127:0] set);
    bit           rdy;
    int           ns;
    longint       old_wr;
    logic [127:0] head;
    @(negedge clk);
    reset = rst; start_run_i = st; run_count_i = cnt[30:0]; base_addr_i = b;
    result_valid_i = v;
    result_0_i = set[31:0]; result_1_i = set[63:32];
    result_2_i = set[95:64]; result_3_i = set[127:96];
    #1;
    chk("idle", idle_o, m_st == 0);
    chk("run", run_o, m_st == 1);
    chk("done", done_o, m_st == 2);
    chk("ready", ready_o, m_ready());
    chk("we", we_b2_o, m_we);
    chk("ce", ce_b2_o, m_we);
    chk("addr", addr_b2_o, m_addr);
    chk("data", d_b2_o, m_d);
    chk("overflow", overflow_o, m_ovf);
    if (rst) begin
      m_reset();
    end else begin
      rdy    = m_ready();
      ns     = m_st;
      old_wr = m_wr;
      m_we   = 0;
      if (m_st == 1 && m_q.size() > 0) begin
        head   = m_q[0];
        m_addr = 12'((longint'(m_base) + 4 * m_wr + m_lane) % 4096);
        m_d    = head[m_lane*32 +: 32];
        m_we   = 1;
        if (m_lane == 3) begin
          void'(m_q.pop_front());
          m_wr++;
          m_lane = 0;
        end else m_lane++;
      end
      if (m_st == 1 && v) begin
        if (rdy) begin m_q.push_back(set); m_acc++; end
        else m_ovf = 1;
      end
      case (m_st)
        0: if (st) begin
          ns = 1; m_num = cnt[30:0]; m_base = b; m_ovf = 0;
          m_acc = 0; m_wr = 0; m_lane = 0;
        end
        1: if (old_wr == m_num) ns = 2;
        default: ns = 0;
      endcase
      m_st = ns;
    end
  endtask

  function automatic logic [127:0] next_set();
    return {dseq + 32'd3, dseq + 32'd2, dseq + 32'd1, dseq};
  endfunction

  // mode 0: honor ready with pct probability; mode 1: 6 blind pulses then honor ready
  task automatic run_test(input logic [11:0] b, input int unsigned cnt, input int mode,
                          input int pct);
    bit v, st;
    step(0, 1, cnt, b, 0, '0);
    for (int k = 0; k < 400 && m_st != 0; k++) begin
      if (mode == 1 && k < 6) v = 1;
      else v = m_ready() && ($urandom_range(99) < pct);
      st = (k == 0) || ($urandom_range(3) == 0);
      step(0, st, $urandom_range(15), 12'($urandom), v, next_set());
      if (v) dseq += 4;
    end
    chk("run_timeout", m_st, 0);
  endtask

  initial begin
    reset = 1; start_run_i = 0; run_count_i = 0; base_addr_i = 0; result_valid_i = 0;
    result_0_i = 0; result_1_i = 0; result_2_i = 0; result_3_i = 0;
    m_reset();
    dseq = 1;
    repeat (2) @(posedge clk);
    step(1, 0, 0, 0, 0, '0);
    step(0, 0, 0, 0, 1, '1);

    run_test(12'h010, 2, 0, 100);
    run_test(12'h000, 8, 0, 100);
    run_test(12'h040, 8, 1, 100);
    chk("ovf_sticky_after_run", overflow_o, 1'b1);
    run_test(12'hFFC, 2, 0, 100);
    run_test(12'h123, 0, 0, 100);

    // Reset mid-run with sets buffered, then a clean run must see no stale data.
    step(0, 1, 8, 12'h200, 0, '0);
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 0, 0, 1, next_set());
      dseq += 4;
    end
    chk("buffered_before_reset", m_q.size() >= 2, 1'b1);
    step(1, 0, 0, 0, 1, next_set());
    step(0, 0, 0, 0, 1, next_set());
    step(0, 0, 0, 0, 0, '0);
    run_test(12'h300, 1, 0, 100);

    for (int r = 0; r < 12; r++)
      run_test(12'($urandom), $urandom_range(9), $urandom_range(1), $urandom_range(100, 30));
    step(0, 0, 0, 0, 0, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
